// File: rtl/evt_enc_pkg.sv
// Shared types and constants for the event encoder.
package evt_enc_pkg;

  localparam int DEF_N = 8;
  localparam int DEF_W = $clog2(DEF_N);

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  localparam logic [DEF_N-1:0] ZERO_VEC = '0;

endpackage

// File: rtl/event_encoder_8x3_lsb_find.sv
// Combinational lowest-set-bit finder: binary index, one-hot mask and any-set flag.
module lsb_find #(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] i_vec,
  output logic [W-1:0] o_idx,
  output logic [N-1:0] o_mask,
  output logic         o_any
);

  // Two's-complement trick isolates the lowest set bit.
  assign o_mask = i_vec & (~i_vec + N'(1));
  assign o_any  = |i_vec;

  always_comb begin
    o_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_vec[i]) o_idx = W'(i);
    end
  end

endmodule

// File: rtl/event_encoder_8x3.sv
// Multi-hot event vector to LSB-first index stream with valid/ready on both sides.
// Optional build macro EVT_ENC_ZERO_ERR_EN enables the zero_err pulse on all-zero vectors.
module event_encoder_8x3
  import evt_enc_pkg::*;
#(
  parameter  int N = DEF_N,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_vec,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic         out_last,
  output logic         zero_err
);

  state_t         r_state;
  state_t         w_state_nxt;
  logic [N-1:0]   r_pending;
  logic [W-1:0]   w_idx;
  logic [N-1:0]   w_mask;
  logic           w_any;
  logic           w_last;
  logic           w_accept;
  logic           w_beat;

  lsb_find #(.N(N)) u_lsb_find (
    .i_vec  (r_pending),
    .o_idx  (w_idx),
    .o_mask (w_mask),
    .o_any  (w_any)
  );

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DRAIN);
  assign w_accept  = in_valid && in_ready;
  assign w_beat    = out_valid && out_ready;
  assign w_last    = w_any && ((r_pending & ~w_mask) == '0);
  assign out_idx   = out_valid ? w_idx : '0;
  assign out_last  = out_valid && w_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept && (in_vec != N'(ZERO_VEC))) w_state_nxt = DRAIN;
      DRAIN:   if (w_beat && w_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending <= '0;
    end else if (w_accept) begin
      r_pending <= in_vec;
    end else if (w_beat) begin
      r_pending <= r_pending & ~w_mask;
    end
  end

`ifdef EVT_ENC_ZERO_ERR_EN
  logic r_zero_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_zero_err <= 1'b0;
    else     r_zero_err <= w_accept && (in_vec == N'(ZERO_VEC));
  end

  assign zero_err = r_zero_err;
`else
  assign zero_err = 1'b0;
`endif

endmodule
